// File: rtl/sm_ahb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sm_ahb_arbiter_if
// Brief    : Request/ack ports of both masters plus the AHB-Lite side.
// Revision : 1.0 - initial release
// ============================================================================
interface sm_ahb_arbiter_if;
    logic        m0_req;
    logic [31:0] m0_addr;
    logic        m0_we;
    logic [31:0] m0_wdata;
    logic        m0_ack;
    logic        m0_err;
    logic [31:0] m0_rdata;
    logic        m0_gnt;

    logic        m1_req;
    logic [31:0] m1_addr;
    logic        m1_we;
    logic [31:0] m1_wdata;
    logic        m1_ack;
    logic        m1_err;
    logic [31:0] m1_rdata;
    logic        m1_gnt;

    logic [31:0] HADDR;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    // The arbiter is the request slave and the AHB master.
    modport slave (
        input  m0_req, m0_addr, m0_we, m0_wdata,
        output m0_ack, m0_err, m0_rdata, m0_gnt,
        input  m1_req, m1_addr, m1_we, m1_wdata,
        output m1_ack, m1_err, m1_rdata, m1_gnt,
        output HADDR, HWRITE, HTRANS, HSIZE, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    // Requesting masters together with the AHB slave they reach.
    modport master (
        output m0_req, m0_addr, m0_we, m0_wdata,
        input  m0_ack, m0_err, m0_rdata, m0_gnt,
        output m1_req, m1_addr, m1_we, m1_wdata,
        input  m1_ack, m1_err, m1_rdata, m1_gnt,
        input  HADDR, HWRITE, HTRANS, HSIZE, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface
`default_nettype wire

// File: rtl/sm_ahb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sm_ahb_arbiter
// Brief    : Two-master arbiter running single NONSEQ word transfers on AHB-Lite.
// Revision : 1.0 - initial release
// ============================================================================
module sm_ahb_arbiter #(
    parameter int FIXED_PRIO     = 0,
    parameter int TIMEOUT_CYCLES = 16
) (
    input wire              clk,
    input wire              rst,
    sm_ahb_arbiter_if.slave bus
);
    localparam logic [1:0] C_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] C_HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] C_HSIZE_WORD    = 3'b010;
    localparam logic [8:0] C_TIMEOUT       = 9'(TIMEOUT_CYCLES);
    localparam logic [7:0] C_CNT_MAX       = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic        r_owner;
    logic        r_lastGnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [7:0]  r_waitCnt;
    logic [31:0] r_m0Rdata;
    logic [31:0] r_m1Rdata;
    logic        r_m0Err;
    logic        r_m1Err;

    logic        w_anyReq;
    logic        w_pickM1;
    logic        w_grant;
    logic        w_dataDone;
    logic        w_timeout;
    logic        w_finish;
    logic [8:0]  w_cntInc;
    logic [31:0] w_resultData;
    logic        w_resultErr;

    // Tie goes to the master that did not win last time unless M0 is fixed-priority.
    always_comb begin
        w_anyReq = bus.m0_req | bus.m1_req;
        w_pickM1 = bus.m1_req;
        if (bus.m0_req && bus.m1_req) begin
            w_pickM1 = (FIXED_PRIO != 0) ? 1'b0 : ~r_lastGnt;
        end
    end

    assign w_grant      = (r_state == S_IDLE) && w_anyReq;
    assign w_cntInc     = {1'b0, r_waitCnt} + 9'd1;
    assign w_dataDone   = (r_state == S_DATA) && bus.HREADY;
    assign w_timeout    = (r_state == S_DATA) && !bus.HREADY && (w_cntInc >= C_TIMEOUT);
    assign w_finish     = w_dataDone | w_timeout;
    assign w_resultData = (w_dataDone && !r_we) ? bus.HRDATA : 32'h0;
    assign w_resultErr  = w_dataDone ? bus.HRESP : 1'b1;

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (w_anyReq)   w_nextState = S_ADDR;
            S_ADDR:  if (bus.HREADY) w_nextState = S_DATA;
            S_DATA:  if (w_finish)   w_nextState = S_RESP;
            S_RESP:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Winner's request is captured so the master's own signals are not needed later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner   <= 1'b0;
            r_lastGnt <= 1'b1;
            r_we      <= 1'b0;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
        end else if (w_grant) begin
            r_owner   <= w_pickM1;
            r_lastGnt <= w_pickM1;
            r_we      <= w_pickM1 ? bus.m1_we    : bus.m0_we;
            r_addr    <= w_pickM1 ? bus.m1_addr  : bus.m0_addr;
            r_wdata   <= w_pickM1 ? bus.m1_wdata : bus.m0_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_waitCnt <= 8'h0;
        end else if ((r_state == S_ADDR) && bus.HREADY) begin
            r_waitCnt <= 8'h0;
        end else if ((r_state == S_DATA) && !bus.HREADY && (r_waitCnt != C_CNT_MAX)) begin
            r_waitCnt <= r_waitCnt + 8'd1;
        end
    end

    // Results are per master so each keeps its last rdata/err until its next ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m0Rdata <= 32'h0;
            r_m0Err   <= 1'b0;
            r_m1Rdata <= 32'h0;
            r_m1Err   <= 1'b0;
        end else if (w_finish) begin
            if (r_owner) begin
                r_m1Rdata <= w_resultData;
                r_m1Err   <= w_resultErr;
            end else begin
                r_m0Rdata <= w_resultData;
                r_m0Err   <= w_resultErr;
            end
        end
    end

    assign bus.HTRANS   = (r_state == S_ADDR) ? C_HTRANS_NONSEQ : C_HTRANS_IDLE;
    assign bus.HADDR    = (r_state == S_ADDR) ? r_addr : 32'h0;
    assign bus.HWRITE   = (r_state == S_ADDR) && r_we;
    assign bus.HSIZE    = C_HSIZE_WORD;
    assign bus.HWDATA   = (r_state == S_DATA) ? r_wdata : 32'h0;

    assign bus.m0_gnt   = (r_state != S_IDLE) && !r_owner;
    assign bus.m1_gnt   = (r_state != S_IDLE) && r_owner;
    assign bus.m0_ack   = (r_state == S_RESP) && !r_owner;
    assign bus.m1_ack   = (r_state == S_RESP) && r_owner;
    assign bus.m0_rdata = r_m0Rdata;
    assign bus.m0_err   = r_m0Err;
    assign bus.m1_rdata = r_m1Rdata;
    assign bus.m1_err   = r_m1Err;
endmodule
`default_nettype wire

// File: tb/tb_sm_ahb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm_ahb_arbiter
// Brief    : Directed scenarios plus randomized traffic against a transfer-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sm_ahb_arbiter;
    localparam int C_TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    sm_ahb_arbiter_if busA();
    sm_ahb_arbiter_if busB();

    sm_ahb_arbiter #(.FIXED_PRIO(0), .TIMEOUT_CYCLES(C_TIMEOUT)) dut   (.clk(clk), .rst(rst), .bus(busA));
    sm_ahb_arbiter #(.FIXED_PRIO(1), .TIMEOUT_CYCLES(C_TIMEOUT)) dutFp (.clk(clk), .rst(rst), .bus(busB));

    always #5 clk = ~clk;

    task automatic clearInputs();
        busA.m0_req = 0; busA.m0_addr = 0; busA.m0_we = 0; busA.m0_wdata = 0;
        busA.m1_req = 0; busA.m1_addr = 0; busA.m1_we = 0; busA.m1_wdata = 0;
        busA.HRDATA = 0; busA.HREADY = 1; busA.HRESP = 0;
        busB.m0_req = 0; busB.m0_addr = 0; busB.m0_we = 0; busB.m0_wdata = 0;
        busB.m1_req = 0; busB.m1_addr = 0; busB.m1_we = 0; busB.m1_wdata = 0;
        busB.HRDATA = 0; busB.HREADY = 1; busB.HRESP = 0;
    endtask

    // Leaves the bench at a falling edge with reset released and the arbiter idle.
    task automatic doReset();
        @(negedge clk);
        clearInputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clearInputs();
        repeat (2) @(negedge clk);
        checks++;
        if ({busA.HTRANS, busA.HSIZE, busA.HWRITE} !== {2'b00, 3'b010, 1'b0}) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 000100", {busA.HTRANS, busA.HSIZE, busA.HWRITE});
        end
        checks++;
        if ({busA.HADDR, busA.HWDATA} !== 64'h0) begin
            errors++; $display("FAIL reset_addr_data: got %h expected 0", {busA.HADDR, busA.HWDATA});
        end
        checks++;
        if ({busA.m0_ack, busA.m1_ack, busA.m0_gnt, busA.m1_gnt, busA.m0_err, busA.m1_err} !== 6'b0) begin
            errors++; $display("FAIL reset_handshake: got %b expected 000000",
                {busA.m0_ack, busA.m1_ack, busA.m0_gnt, busA.m1_gnt, busA.m0_err, busA.m1_err});
        end
        checks++;
        if ({busA.m0_rdata, busA.m1_rdata} !== 64'h0) begin
            errors++; $display("FAIL reset_rdata: got %h expected 0", {busA.m0_rdata, busA.m1_rdata});
        end
        checks++;
        if ({busB.HTRANS, busB.HSIZE, busB.m0_gnt, busB.m1_gnt} !== {2'b00, 3'b010, 2'b00}) begin
            errors++; $display("FAIL reset_fp_ctrl: got %b expected 0001000", {busB.HTRANS, busB.HSIZE, busB.m0_gnt, busB.m1_gnt});
        end
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        int nonseq = 0;
        doReset();
        busA.m0_req = 1; busA.m0_addr = 32'h0000_0010; busA.m0_we = 0;
        busA.HRDATA = 32'hCAFE_0001; busA.HREADY = 1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (busA.HTRANS == 2'b10) nonseq++;
            if (k == 1) begin
                checks++;
                if ({busA.HTRANS, busA.HADDR, busA.HWRITE, busA.m0_gnt} !== {2'b10, 32'h10, 1'b0, 1'b1}) begin
                    errors++; $display("FAIL read_addr_phase: got trans=%b addr=%h we=%b gnt=%b expected 10/00000010/0/1",
                        busA.HTRANS, busA.HADDR, busA.HWRITE, busA.m0_gnt);
                end
            end
            checks++;
            if (busA.m0_ack !== (k == 3)) begin
                errors++; $display("FAIL read_ack_cycle%0d: got %b expected %b", k, busA.m0_ack, (k == 3));
            end
            if (k == 3) begin
                checks++;
                if ({busA.m0_rdata, busA.m0_err} !== {32'hCAFE_0001, 1'b0}) begin
                    errors++; $display("FAIL read_result: got rdata=%h err=%b expected cafe0001/0", busA.m0_rdata, busA.m0_err);
                end
                busA.m0_req = 0;
            end
        end
        checks++;
        if (nonseq != 1) begin
            errors++; $display("FAIL read_nonseq_count: got %0d expected 1", nonseq);
        end
        checks++;
        if (busA.m0_gnt !== 1'b0) begin
            errors++; $display("FAIL read_gnt_release: got %b expected 0", busA.m0_gnt);
        end
    endtask

    task automatic test_round_robin();
        int  nAck = 0;
        int  lastCyc = 0;
        bit  expM1 = 0;
        doReset();
        busA.m0_req = 1; busA.m0_addr = 32'h100; busA.m0_we = 0;
        busA.m1_req = 1; busA.m1_addr = 32'h200; busA.m1_we = 0;
        busA.HRDATA = 32'h1111_2222; busA.HREADY = 1;
        for (int k = 1; k <= 40 && nAck < 4; k++) begin
            @(negedge clk);
            if (busA.m0_ack || busA.m1_ack) begin
                checks++;
                if ({busA.m0_ack, busA.m1_ack} !== {~expM1, expM1}) begin
                    errors++; $display("FAIL rr_order ack%0d: got m0/m1=%b%b expected %b%b",
                        nAck, busA.m0_ack, busA.m1_ack, ~expM1, expM1);
                end
                checks++;
                if ((k - lastCyc) != ((nAck == 0) ? 3 : 4)) begin
                    errors++; $display("FAIL rr_spacing ack%0d: got %0d cycles expected %0d", nAck, k - lastCyc, (nAck == 0) ? 3 : 4);
                end
                lastCyc = k;
                nAck++;
                expM1 = ~expM1;
                if (nAck == 4) begin
                    busA.m0_req = 0; busA.m1_req = 0;
                end
            end
        end
        checks++;
        if (nAck != 4) begin
            errors++; $display("FAIL rr_ack_count: got %0d expected 4", nAck);
        end
        busA.m0_req = 0; busA.m1_req = 0;
    endtask

    task automatic test_fixed_prio();
        int m0Acks = 0;
        int m1Acks = 0;
        doReset();
        busB.m0_req = 1; busB.m0_addr = 32'h300; busB.m1_req = 1; busB.m1_addr = 32'h400; busB.HREADY = 1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (busB.m0_ack) m0Acks++;
            if (busB.m1_ack) m1Acks++;
            checks++;
            if (busB.m1_gnt !== 1'b0) begin
                errors++; $display("FAIL fp_m1_gnt cycle%0d: got %b expected 0", k, busB.m1_gnt);
            end
        end
        checks++;
        if (m0Acks != 6 || m1Acks != 0) begin
            errors++; $display("FAIL fp_ack_counts: got m0=%0d m1=%0d expected m0=6 m1=0", m0Acks, m1Acks);
        end
        busB.m0_req = 0; busB.m1_req = 0;
    endtask

    task automatic test_write_wait();
        doReset();
        busA.m1_req = 1; busA.m1_addr = 32'h20; busA.m1_we = 1; busA.m1_wdata = 32'h1234;
        busA.HRDATA = 32'hDEAD_BEEF; busA.HREADY = 1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if ({busA.HTRANS, busA.HADDR, busA.HWRITE, busA.m1_gnt} !== {2'b10, 32'h20, 1'b1, 1'b1}) begin
                    errors++; $display("FAIL write_addr_phase: got trans=%b addr=%h we=%b gnt=%b expected 10/00000020/1/1",
                        busA.HTRANS, busA.HADDR, busA.HWRITE, busA.m1_gnt);
                end
            end
            if (k >= 2 && k <= 5) begin
                checks++;
                if ({busA.HTRANS, busA.HWDATA} !== {2'b00, 32'h1234}) begin
                    errors++; $display("FAIL write_data_phase cycle%0d: got trans=%b hwdata=%h expected 00/00001234",
                        k, busA.HTRANS, busA.HWDATA);
                end
            end
            checks++;
            if (busA.m1_ack !== (k == 6)) begin
                errors++; $display("FAIL write_ack_cycle%0d: got %b expected %b", k, busA.m1_ack, (k == 6));
            end
            if (k == 6) begin
                checks++;
                if ({busA.m1_rdata, busA.m1_err} !== {32'h0, 1'b0}) begin
                    errors++; $display("FAIL write_result: got rdata=%h err=%b expected 0/0", busA.m1_rdata, busA.m1_err);
                end
                busA.m1_req = 0;
            end
            if (k >= 2 && k <= 4) busA.HREADY = 0;
            else busA.HREADY = 1;
        end
    endtask

    task automatic test_timeout();
        doReset();
        busA.m0_req = 1; busA.m0_addr = 32'h40; busA.m0_we = 0;
        busA.HRDATA = 32'h5555_AAAA; busA.HREADY = 1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            checks++;
            if (busA.m0_ack !== (k == 18)) begin
                errors++; $display("FAIL timeout_ack_cycle%0d: got %b expected %b", k, busA.m0_ack, (k == 18));
            end
            if (k == 18) begin
                checks++;
                if ({busA.m0_rdata, busA.m0_err} !== {32'h0, 1'b1}) begin
                    errors++; $display("FAIL timeout_result: got rdata=%h err=%b expected 0/1", busA.m0_rdata, busA.m0_err);
                end
                busA.m0_req = 0;
                busA.HREADY = 1;
            end else if (k == 2) begin
                busA.HREADY = 0;
            end
        end
        busA.HREADY = 1;
    endtask

    task automatic test_async_reset();
        int seenAck = 0;
        doReset();
        busA.m0_req = 1; busA.m0_addr = 32'h80; busA.m0_we = 0; busA.HREADY = 1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 2) busA.HREADY = 0;
        end
        checks++;
        if (busA.m0_gnt !== 1'b1) begin
            errors++; $display("FAIL arst_pre_gnt: got %b expected 1", busA.m0_gnt);
        end
        #1 rst = 1'b1;
        busA.m0_req = 0;
        #1;
        checks++;
        if ({busA.HTRANS, busA.m0_gnt, busA.m0_ack} !== 4'b0000) begin
            errors++; $display("FAIL arst_immediate: got trans/gnt/ack=%b expected 0000", {busA.HTRANS, busA.m0_gnt, busA.m0_ack});
        end
        @(negedge clk);
        checks++;
        if ({busA.HTRANS, busA.m0_gnt, busA.m0_ack} !== 4'b0000) begin
            errors++; $display("FAIL arst_next_cycle: got trans/gnt/ack=%b expected 0000", {busA.HTRANS, busA.m0_gnt, busA.m0_ack});
        end
        rst = 1'b0;
        busA.HREADY = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (busA.m0_ack || busA.m1_ack) seenAck++;
        end
        checks++;
        if (seenAck != 0) begin
            errors++; $display("FAIL arst_no_ack: got %0d acks expected 0", seenAck);
        end
        busA.m1_req = 1; busA.m1_addr = 32'hC0; busA.m1_we = 0; busA.HRDATA = 32'h600D_F00D;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if (busA.m1_ack !== (k == 3)) begin
                errors++; $display("FAIL arst_m1_ack_cycle%0d: got %b expected %b", k, busA.m1_ack, (k == 3));
            end
            if (k == 3) begin
                checks++;
                if ({busA.m1_rdata, busA.m1_err} !== {32'h600D_F00D, 1'b0}) begin
                    errors++; $display("FAIL arst_m1_result: got rdata=%h err=%b expected 600df00d/0", busA.m1_rdata, busA.m1_err);
                end
                busA.m1_req = 0;
            end
        end
    endtask

    // Transfer-level model: masters hold a request until acked; the bench is the AHB
    // slave, so it knows when each address/data phase is accepted and what it returned.
    task automatic test_random();
        logic [31:0] mAddr [2];
        logic [31:0] mWdata [2];
        logic        mWe [2];
        bit          pend [2];
        bit          addrPh = 0, dataPh = 0, busy = 0, lastWin = 1, owner = 0, ackNow;
        int          lowCnt = 0, nextGrant = 1, stall = 0, done = 0;
        logic [31:0] expRdata, hd;
        logic        expErr, rq0, rq1, hr, hresp;
        expRdata = 0; expErr = 0;
        for (int m = 0; m < 2; m++) begin
            mAddr[m] = 0; mWdata[m] = 0; mWe[m] = 0; pend[m] = 0;
        end
        doReset();
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            rq0 = busA.m0_req; rq1 = busA.m1_req; hr = busA.HREADY; hd = busA.HRDATA; hresp = busA.HRESP;
            ackNow = 0;
            if (dataPh) begin
                if (hr || (lowCnt + 1 >= C_TIMEOUT)) begin
                    ackNow = 1; dataPh = 0; busy = 0; nextGrant = k + 2;
                    expErr   = hr ? hresp : 1'b1;
                    expRdata = (hr && !mWe[owner]) ? hd : 32'h0;
                end else begin
                    lowCnt++;
                end
            end else if (addrPh && hr) begin
                addrPh = 0; dataPh = 1; lowCnt = 0;
            end
            if (!busy && k >= nextGrant && (rq0 || rq1)) begin
                owner = (rq0 && rq1) ? ~lastWin : rq1;
                lastWin = owner; busy = 1; addrPh = 1;
            end

            checks++;
            if (busA.HTRANS !== (addrPh ? 2'b10 : 2'b00)) begin
                errors++; $display("FAIL rand_htrans cycle%0d: got %b expected %b", k, busA.HTRANS, addrPh ? 2'b10 : 2'b00);
            end
            if (addrPh) begin
                checks++;
                if ({busA.HADDR, busA.HWRITE} !== {mAddr[owner], mWe[owner]}) begin
                    errors++; $display("FAIL rand_addr cycle%0d: got %h/%b expected %h/%b (master %0d)",
                        k, busA.HADDR, busA.HWRITE, mAddr[owner], mWe[owner], owner);
                end
            end
            if (dataPh) begin
                checks++;
                if (busA.HWDATA !== mWdata[owner]) begin
                    errors++; $display("FAIL rand_hwdata cycle%0d: got %h expected %h", k, busA.HWDATA, mWdata[owner]);
                end
            end
            checks++;
            if ({busA.m0_ack, busA.m1_ack} !== {ackNow && !owner, ackNow && owner}) begin
                errors++; $display("FAIL rand_ack cycle%0d: got %b%b expected %b%b",
                    k, busA.m0_ack, busA.m1_ack, ackNow && !owner, ackNow && owner);
            end
            checks++;
            if ({busA.m0_gnt, busA.m1_gnt} !== {(busy || ackNow) && !owner, (busy || ackNow) && owner}) begin
                errors++; $display("FAIL rand_gnt cycle%0d: got %b%b expected %b%b", k, busA.m0_gnt, busA.m1_gnt,
                    (busy || ackNow) && !owner, (busy || ackNow) && owner);
            end
            if (ackNow) begin
                checks++;
                if ((owner ? {busA.m1_rdata, busA.m1_err} : {busA.m0_rdata, busA.m0_err}) !== {expRdata, expErr}) begin
                    errors++; $display("FAIL rand_result cycle%0d master%0d: got %h expected %h", k, owner,
                        owner ? {busA.m1_rdata, busA.m1_err} : {busA.m0_rdata, busA.m0_err}, {expRdata, expErr});
                end
                done++;
                pend[owner] = 0;
            end

            for (int m = 0; m < 2; m++) begin
                if (!pend[m] && $urandom_range(0, 2) == 0) begin
                    pend[m] = 1;
                    mAddr[m] = $urandom & 32'hFFFF_FFFC;
                    mWe[m] = 1'($urandom_range(0, 1));
                    mWdata[m] = $urandom;
                end
            end
            busA.m0_req = pend[0]; busA.m0_addr = mAddr[0]; busA.m0_we = mWe[0]; busA.m0_wdata = mWdata[0];
            busA.m1_req = pend[1]; busA.m1_addr = mAddr[1]; busA.m1_we = mWe[1]; busA.m1_wdata = mWdata[1];
            if (stall > 0) begin
                stall--;
                busA.HREADY = 0;
            end else begin
                if ($urandom_range(0, 79) == 0) stall = 18;
                busA.HREADY = ($urandom_range(0, 3) != 0);
            end
            busA.HRDATA = $urandom;
            busA.HRESP = ($urandom_range(0, 7) == 0);
        end
        checks++;
        if (done < 30) begin
            errors++; $display("FAIL rand_progress: got %0d transfers expected at least 30", done);
        end
        clearInputs();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_fixed_prio();
        test_write_wait();
        test_timeout();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
